mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// CPU memory responder: byte RAM plus memory-mapped RX/TX byte FIFOs, prog-stop flag and cycle counter.
// Define RESP_CLK_COUNTER_EN to build the 32-bit cycle counter and its read snapshot.

module mem_responder_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       buf_r [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = empty ? 8'h00 : buf_r[rd_ptr_r];

  // Pointer and occupancy tracking; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge clk_in) begin
    if (do_push_s) buf_r[wr_ptr_r] <= wdata;
  end
endmodule

module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop
);
  logic [7:0]            ram_r [0:(1 << ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic                  is_io_s;
  logic                  is_data_s;
  logic                  is_ctl_s;
  logic                  is_cnt_s;
  logic                  rdy_s;
  logic                  ram_we_s;
  logic                  rx_pop_s;
  logic                  tx_push_s;
  logic [7:0]            tx_wdata_s;
  logic [7:0]            rx_head_s;
  logic                  rx_full_s;
  logic                  rx_empty_s;
  logic                  tx_full_s;
  logic                  tx_empty_s;
  logic [7:0]            cnt_byte_s;
  logic [7:0]            rd_data_s;
  logic                  unused_s;

  assign unused_s  = ^mem_a[31:18];
  assign ram_idx_s = mem_a[ADDR_WIDTH-1:0];
  assign is_io_s   = (mem_a[17:16] == 2'b11);
  assign is_data_s = (mem_a[17:0] == 18'h30000);
  assign is_ctl_s  = (mem_a[17:0] == 18'h30004);
  assign is_cnt_s  = (mem_a[17:2] == 16'hC001);

  assign rdy_out  = rdy_s;
  assign rx_ready = !rx_full_s;
  assign tx_valid = !tx_empty_s;

  mem_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid),
    .pop    (rx_pop_s),
    .wdata  (rx_data),
    .rdata  (rx_head_s),
    .full   (rx_full_s),
    .empty  (rx_empty_s)
  );

  mem_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push_s),
    .pop    (tx_ready),
    .wdata  (tx_wdata_s),
    .rdata  (tx_data),
    .full   (tx_full_s),
    .empty  (tx_empty_s)
  );

  // Access arbitration: stall decision, FIFO push/pop and RAM write enable
  always_comb begin
    rdy_s      = 1'b1;
    ram_we_s   = 1'b0;
    rx_pop_s   = 1'b0;
    tx_push_s  = 1'b0;
    tx_wdata_s = 8'h00;
    if (!rst_in) begin
      rdy_s = 1'b0;
    end else if (!is_io_s) begin
      ram_we_s = mem_wr;
    end else if (is_data_s && mem_wr) begin
      tx_wdata_s = mem_dout;
      if (mem_dout == 8'h00) begin
        tx_push_s = 1'b0;
      end else if (tx_full_s) begin
        rdy_s = 1'b0;
      end else begin
        tx_push_s = 1'b1;
      end
    end else if (is_data_s) begin
      if (rx_empty_s) begin
        rdy_s = 1'b0;
      end else begin
        rx_pop_s = 1'b1;
      end
    end else if (is_ctl_s && mem_wr) begin
      // stop marker is a 0x00 byte queued behind pending output
      if (tx_full_s) begin
        rdy_s = 1'b0;
      end else begin
        tx_push_s = 1'b1;
      end
    end else begin
      rdy_s = 1'b1;
    end
  end

`ifdef RESP_CLK_COUNTER_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] snap_r;

  // Free-running cycle counter; reading 0x30004 freezes a snapshot for the upper bytes
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cycle_cnt_r <= 32'h0000_0000;
      snap_r      <= 32'h0000_0000;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
      if (rdy_s && !mem_wr && is_ctl_s) snap_r <= cycle_cnt_r;
    end
  end

  // Little-endian byte select; byte 0 comes live from the counter
  always_comb begin
    cnt_byte_s = 8'h00;
    case (mem_a[1:0])
      2'b00:   cnt_byte_s = cycle_cnt_r[7:0];
      2'b01:   cnt_byte_s = snap_r[15:8];
      2'b10:   cnt_byte_s = snap_r[23:16];
      2'b11:   cnt_byte_s = snap_r[31:24];
      default: cnt_byte_s = 8'h00;
    endcase
  end
`else
  assign cnt_byte_s = 8'h00;
`endif

  // Read data source select
  always_comb begin
    rd_data_s = 8'h00;
    if (!is_io_s) begin
      rd_data_s = ram_r[ram_idx_s];
    end else if (is_data_s) begin
      rd_data_s = rx_head_s;
    end else if (is_cnt_s) begin
      rd_data_s = cnt_byte_s;
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Registered read data and sticky stop flag
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_din   <= 8'h00;
      prog_stop <= 1'b0;
    end else begin
      if (rdy_s && !mem_wr) mem_din <= rd_data_s;
      if (tx_push_s && is_ctl_s) prog_stop <= 1'b1;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (ram_we_s) ram_r[ram_idx_s] <= mem_dout;
  end
endmodule
